// File: rtl/pipe_pkg.sv
// Shared pipeline constants, control-bit positions and the forwarding-select encoding.
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 8;

    localparam int CTRL_MEMREAD = 0;
    localparam int CTRL_WRITEEN = 1;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2,
        FWD_ZERO  = 2'd3
    } fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// One source operand: r0 guard, then EX/MEM over MEM/WB over register-file data.
module fwd_mux #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              exmem_writeEn,
    input  logic [ADDR_W-1:0] exmem_addr,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_writeEn,
    input  logic [ADDR_W-1:0] memwb_addr,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic [DATA_W-1:0] data_rf,
    output logic [DATA_W-1:0] operand,
    output pipe_pkg::fwd_sel_e sel
);
    import pipe_pkg::*;

    always_comb begin
        sel = FWD_RF;
        if (addr == '0)
            sel = FWD_ZERO;
        else if (exmem_writeEn && (exmem_addr == addr))
            sel = FWD_EXMEM;
        else if (memwb_writeEn && (memwb_addr == addr))
            sel = FWD_MEMWB;
    end

    always_comb begin
        operand = data_rf;
        case (sel)
            FWD_ZERO:  operand = '0;
            FWD_EXMEM: operand = exmem_data;
            FWD_MEMWB: operand = memwb_data;
            default:   operand = data_rf;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, load-use bubble insertion and a
// saturating stall counter for debug.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    input  logic              use1,
    input  logic              use2,
    input  logic [ADDR_W-1:0] dest_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              flush,
    input  logic              exmem_writeEn,
    input  logic [ADDR_W-1:0] exmem_addr,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_writeEn,
    input  logic [ADDR_W-1:0] memwb_addr,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [CNT_W-1:0]  stall_count
);
    import pipe_pkg::*;

    logic [DATA_W-1:0] op_a, op_b;
    fwd_sel_e          sel_a, sel_b;
    logic              hazard;

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .addr(read1), .exmem_writeEn(exmem_writeEn), .exmem_addr(exmem_addr),
        .exmem_data(exmem_data), .memwb_writeEn(memwb_writeEn), .memwb_addr(memwb_addr),
        .memwb_data(memwb_data), .data_rf(data1), .operand(op_a), .sel(sel_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .addr(read2), .exmem_writeEn(exmem_writeEn), .exmem_addr(exmem_addr),
        .exmem_data(exmem_data), .memwb_writeEn(memwb_writeEn), .memwb_addr(memwb_addr),
        .memwb_data(memwb_data), .data_rf(data2), .operand(op_b), .sel(sel_b)
    );

    // A load in EX whose result the ID instruction needs cannot be forwarded yet.
    assign hazard = valid_in && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_dest != '0) &&
                    ((use1 && (read1 == ex_dest)) || (use2 && (read2 == ex_dest)));
    assign stall  = reset && hazard && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_opA      <= '0;
            ex_opB      <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
            ex_dest     <= '0;
            stall_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            // Squash and bubble both leave a fully zeroed, invalid bundle.
            if (flush || stall) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                ex_opA   <= '0;
                ex_opB   <= '0;
                ex_imm   <= '0;
                ex_dest  <= '0;
            end else begin
                ex_valid <= valid_in;
                ex_ctrl  <= valid_in ? ctrl_in : '0;
                ex_opA   <= (sel_a == FWD_ZERO) ? '0 : op_a;
                ex_opB   <= (sel_b == FWD_ZERO) ? '0 : op_b;
                ex_imm   <= imm_in;
                ex_dest  <= dest_in;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cases plus random traffic checked
// against a transaction-level model of the EX register contents.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int NW = 6;
    localparam int CNT_MAX = (1 << NW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in, use1, use2, flush, exmem_writeEn, memwb_writeEn;
    logic [AW-1:0] read1, read2, dest_in, exmem_addr, memwb_addr;
    logic [DW-1:0] imm_in, data1, data2, exmem_data, memwb_data;
    logic [CW-1:0] ctrl_in;
    logic          stall, ex_valid;
    logic [DW-1:0] ex_opA, ex_opB, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [AW-1:0] ex_dest;
    logic [NW-1:0] stall_count;

    always #5 clock = ~clock;

    id_ex_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .read1(read1), .read2(read2),
        .use1(use1), .use2(use2), .dest_in(dest_in), .imm_in(imm_in), .ctrl_in(ctrl_in),
        .data1(data1), .data2(data2), .flush(flush), .exmem_writeEn(exmem_writeEn),
        .exmem_addr(exmem_addr), .exmem_data(exmem_data), .memwb_writeEn(memwb_writeEn),
        .memwb_addr(memwb_addr), .memwb_data(memwb_data), .stall(stall), .ex_valid(ex_valid),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_dest(ex_dest), .stall_count(stall_count)
    );

    typedef struct {
        logic vin; logic [AW-1:0] r1, r2; logic u1, u2; logic [AW-1:0] dest;
        logic [DW-1:0] imm; logic [CW-1:0] ctrl; logic [DW-1:0] d1, d2; logic fl;
        logic exw; logic [AW-1:0] exa; logic [DW-1:0] exd;
        logic mww; logic [AW-1:0] mwa; logic [DW-1:0] mwd;
    } stim_t;

    typedef struct {
        logic v; logic [DW-1:0] a, b, imm; logic [CW-1:0] ctrl; logic [AW-1:0] dest; int cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;            // predicted EX register contents
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.v = 0; e.a = 0; e.b = 0; e.imm = 0; e.ctrl = 0; e.dest = 0; e.cnt = 0;
        return e;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s.vin = 0; s.r1 = 0; s.r2 = 0; s.u1 = 0; s.u2 = 0; s.dest = 0; s.imm = 0;
        s.ctrl = 0; s.d1 = 0; s.d2 = 0; s.fl = 0; s.exw = 0; s.exa = 0; s.exd = 0;
        s.mww = 0; s.mwa = 0; s.mwd = 0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.vin = ($urandom_range(0, 99) < 85); s.r1 = AW'($urandom_range(0, 7));
        s.r2 = AW'($urandom_range(0, 7)); s.u1 = 1'($urandom); s.u2 = 1'($urandom);
        s.dest = AW'($urandom_range(0, 7)); s.imm = $urandom; s.ctrl = CW'($urandom);
        s.d1 = $urandom; s.d2 = $urandom; s.fl = ($urandom_range(0, 99) < 8);
        s.exw = 1'($urandom); s.exa = AW'($urandom_range(0, 7)); s.exd = $urandom;
        s.mww = 1'($urandom); s.mwa = AW'($urandom_range(0, 7)); s.mwd = $urandom;
        return s;
    endfunction

    // Source operand value as seen by the instruction: r0 is zero, youngest producer wins.
    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] r, input logic [DW-1:0] rf,
                                              input stim_t s);
        if (r == 0) return 0;
        if (s.exw && s.exa == r) return s.exd;
        if (s.mww && s.mwa == r) return s.mwd;
        return rf;
    endfunction

    task automatic drive(input stim_t s);
        valid_in = s.vin; read1 = s.r1; read2 = s.r2; use1 = s.u1; use2 = s.u2;
        dest_in = s.dest; imm_in = s.imm; ctrl_in = s.ctrl; data1 = s.d1; data2 = s.d2;
        flush = s.fl; exmem_writeEn = s.exw; exmem_addr = s.exa; exmem_data = s.exd;
        memwb_writeEn = s.mww; memwb_addr = s.mwa; memwb_data = s.mwd;
    endtask

    task automatic apply(input stim_t s);
        logic needs_load, st;
        exp_t n;
        @(negedge clock);
        drive(s);
        #1;
        needs_load = (s.u1 && s.r1 == m.dest) || (s.u2 && s.r2 == m.dest);
        st = s.vin && m.v && m.ctrl[0] && (m.dest != 0) && needs_load && !s.fl;
        chk("stall", stall, st);
        n = zero_exp();
        n.cnt = (st && m.cnt < CNT_MAX) ? m.cnt + 1 : m.cnt;
        if (!(s.fl || st)) begin
            n.v = s.vin; n.ctrl = s.vin ? s.ctrl : 0;
            n.a = resolve(s.r1, s.d1, s); n.b = resolve(s.r2, s.d2, s);
            n.imm = s.imm; n.dest = s.dest;
        end
        m = n;
        q.push_back(n);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, ex_valid, 0); chk({tag, "_opA"}, ex_opA, 0);
        chk({tag, "_opB"}, ex_opB, 0);     chk({tag, "_imm"}, ex_imm, 0);
        chk({tag, "_ctrl"}, ex_ctrl, 0);   chk({tag, "_dest"}, ex_dest, 0);
        chk({tag, "_cnt"}, stall_count, 0); chk({tag, "_stall"}, stall, 0);
    endtask

    // Monitor: every posedge, compare the DUT bundle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", ex_valid, e.v);
                chk("ex_ctrl", ex_ctrl, e.ctrl);
                chk("stall_count", stall_count, e.cnt);
                if (e.v) begin
                    chk("ex_opA", ex_opA, e.a);   chk("ex_opB", ex_opB, e.b);
                    chk("ex_imm", ex_imm, e.imm); chk("ex_dest", ex_dest, e.dest);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s, ld, us;
        m = zero_exp();
        drive(blank());
        reset = 1'b0;
        #2;
        check_cleared("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Pass-through, no forwarding.
        s = blank(); s.vin = 1; s.r1 = 3; s.d1 = 32'h11; s.r2 = 4; s.d2 = 32'h22;
        s.u1 = 1; s.u2 = 1; s.dest = 9; s.imm = 32'h5; s.ctrl = 8'h02;
        apply(s);
        // EX/MEM beats MEM/WB, then MEM/WB alone.
        s.r1 = 5; s.exw = 1; s.exa = 5; s.exd = 32'hAAAA; s.mww = 1; s.mwa = 5; s.mwd = 32'hBBBB;
        apply(s);
        s.exw = 0;
        apply(s);
        // r0 is never forwarded.
        s = blank(); s.vin = 1; s.r2 = 0; s.d2 = 32'h1234; s.exw = 1; s.exa = 0; s.exd = 32'hFFFF;
        apply(s);

        // Load-use: stall once, then pick the load result up from EX/MEM.
        ld = blank(); ld.vin = 1; ld.ctrl = 8'h01; ld.dest = 7;
        us = blank(); us.vin = 1; us.r1 = 7; us.u1 = 1; us.ctrl = 8'h02; us.dest = 8;
        apply(ld);
        apply(us);
        us.exw = 1; us.exa = 7; us.exd = 32'h1234;
        apply(us);
        // Flush overrides the hazard.
        apply(ld);
        us.exw = 0; us.fl = 1;
        apply(us);

        // Asynchronous reset with a valid bundle in EX and a hazard pending in ID.
        apply(ld);
        @(negedge clock);
        us.fl = 0; drive(us);
        #2 reset = 1'b0;
        #1 check_cleared("midreset");
        drive(blank());
        @(negedge clock);
        reset = 1'b1;
        m = zero_exp();
        us.exw = 0;
        apply(us);

        // Counter saturation with alternating load / dependent use.
        us.fl = 0;
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            apply(ld);
            apply(us);
        end

        for (int i = 0; i < 400; i++) apply(rnd());

        @(negedge clock);
        drive(blank());
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Operand-fetch / ID-EX pipeline register sitting directly downstream of the register file.
- Captures the register file's data1/data2 and resolves forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles.
- Presents a registered operand/control bundle to the ALU stage; also keeps a saturating stall counter for debug.

Parameters:
- DATA_W, 32, operand/immediate width.
- ADDR_W, 5, register address width.
- CTRL_W, 8, opaque decoded-control bundle width; bit 0 = memRead, bit 1 = writeEn, others passed through.
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately when 0.
- valid_in  in  1  decoded instruction present in ID.
- read1, read2  in  ADDR_W  source register addresses (same values driven to the register file).
- use1, use2  in  1  instruction actually consumes read1 / read2.
- dest_in  in  ADDR_W  destination register.
- imm_in  in  DATA_W  sign-extended immediate.
- ctrl_in  in  CTRL_W  decoded control.
- data1, data2  in  DATA_W  register file outputs (valid before posedge).
- flush  in  1  branch/jump squash from EX.
- exmem_writeEn  in  1;  exmem_addr  in  ADDR_W;  exmem_data  in  DATA_W  EX/MEM result.
- memwb_writeEn  in  1;  memwb_addr  in  ADDR_W;  memwb_data  in  DATA_W  MEM/WB result.
- stall  out  1  combinational; holds PC and IF/ID when 1.
- ex_valid  out  1  registered.
- ex_opA, ex_opB  out  DATA_W  registered resolved operands.
- ex_imm  out  DATA_W  registered immediate.
- ex_ctrl  out  CTRL_W  registered control.
- ex_dest  out  ADDR_W  registered destination.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (reset=0, async): ex_valid=0, ex_opA=ex_opB=ex_imm=0, ex_ctrl=0, ex_dest=0, stall_count=0. stall is forced 0 while reset is low.

Operand resolution (combinational, per source, same rule for B):
- If read1==0, result is 0; no forwarding ever applies to r0.
- Else if exmem_writeEn && exmem_addr==read1, use exmem_data.
- Else if memwb_writeEn && memwb_addr==read1, use memwb_data.
- Else use data1.
- EX/MEM has priority over MEM/WB when both match.

Load-use hazard:
- hazard = valid_in && ex_valid && ex_ctrl[0] && ex_dest!=0 && ((use1 && read1==ex_dest) || (use2 && read2==ex_dest)).
- stall = hazard && !flush.

Register update at posedge (when reset=1):
- flush=1: ex_valid←0, ex_ctrl←0; data fields don't care but are zeroed. flush has priority over stall.
- else stall=1: insert bubble (ex_valid←0, ex_ctrl←0). The ID instruction is held upstream and re-presented the next cycle, when it sees the forwarded load result via EX/MEM.
- else: ex_valid←valid_in, ex_ctrl←valid_in ? ctrl_in : 0, ex_opA/ex_opB←resolved operands, ex_imm←imm_in, ex_dest←dest_in.

Latency and stall rules:
- Latency is 1 cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly 1 cycle: the bubble clears ex_ctrl[0], so hazard falls.

stall_count:
- Increments by 1 on each posedge where stall=1.
- Saturates at all-ones; no wrap.

Reset asserted mid-stall:
- Outputs clear immediately.
- After reset release, no stall until a new load reaches EX.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W/ADDR_W/CTRL_W constants.
  - Control bit indices CTRL_MEMREAD=0, CTRL_WRITEEN=1.
  - A forwarding-select enum {FWD_RF, FWD_MEMWB, FWD_EXMEM, FWD_ZERO}.
- One sub-module, fwd_mux, instantiated twice (A and B): takes one source address plus both forwarding buses and data_rf, and returns the resolved operand and the select.

Test Plan:
- Reset mid-operation: reset=0 asynchronously between clock edges with ex_valid=1 -> all ex_* outputs and stall_count read 0 before the next posedge.
- Plain pass-through: read1=3, data1=0x11, read2=4, data2=0x22, no forwarding, valid_in=1 -> next cycle ex_opA=0x11, ex_opB=0x22, ex_valid=1.
- Double match priority: exmem writes r5=0xAAAA and memwb writes r5=0xBBBB, read1=5 -> ex_opA=0xAAAA. With exmem_writeEn=0 -> 0xBBBB.
- r0 guard: read2=0 with exmem_addr=0, exmem_writeEn=1, exmem_data=0xFFFF -> ex_opB=0.
- Load-use: EX holds a load to r7 (ex_ctrl[0]=1, ex_dest=7), ID has read1=7, use1=1 -> stall=1 for one cycle. Next cycle ex_valid=0. Following cycle, with exmem r7=0x1234, ex_opA=0x1234, stall=0, stall_count=1.
- Flush vs stall: hazard present and flush=1 -> stall=0, ex_valid=0 next cycle, stall_count unchanged. Force 2^CNT_W+3 stall cycles -> stall_count holds 0xFFFF.
